mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide execution unit that consumes the two register-file read operands and produces one result for the register-file write port (addr_3 / write_data_3 / write_enable_3).
- Sits in the execute stage beside the ALU, with a valid/ready handshake on both the operand side and the result side.
- Shift-add multiplier and restoring divider share one datapath and complete in N_DATA compute cycles; RISC-V special cases complete early.

Parameters:
N_DATA, 32, operand/result width (even, >= 8)
N_REG_ADDR, 5, destination register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start_valid  in  1  operands/op valid
start_ready  out  1  unit idle, can accept
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a  in  N_DATA  rs1 value (multiplicand/dividend)
operand_b  in  N_DATA  rs2 value (multiplier/divisor)
rd_addr  in  N_REG_ADDR  destination register, passed through
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result  out  N_DATA  computed value
result_rd_addr  out  N_REG_ADDR  captured rd_addr
busy  out  1  state != IDLE

Behaviour:
- Reset (rst low, async): state=IDLE; start_ready=1; result_valid=0; result=0; result_rd_addr=0; busy=0; counter and internal registers cleared. Reset mid-operation aborts the operation with no result emitted.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE: start_ready=1. On start_valid&&start_ready at a clock edge, capture funct3, operands and rd_addr; later input changes are ignored.
  - Divide by zero (funct3[2]=1, operand_b=0) -> DONE.
  - Signed overflow (DIV/REM, a=100..0, b=all-ones) -> DONE.
  - Otherwise MUL (funct3[2]=0) or DIV, with counter=N_DATA-1.
- Sign handling: take magnitudes per op.
  - MUL/MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - DIV/REM: both signed.
  - Negate the final product when the operand signs differ.
  - Quotient is negated when the signs differ; remainder takes the dividend's sign (truncating division).
- MUL: one shift-add step per cycle on a 2*N_DATA-bit accumulator. After the step with counter=0 -> DONE.
  - MUL selects the low N_DATA bits; MULH/MULHSU/MULHU select the high N_DATA bits.
- DIV: one restoring step per cycle (shift, trial subtract, set quotient bit). After the counter=0 step -> DONE.
- Special results:
  - Divide by zero: quotient = all-ones, remainder = operand_a.
  - Overflow: quotient = operand_a, remainder = 0.
- Latency, with the accept edge as E0:
  - Normal ops: result_valid=1 after edge E0+N_DATA.
  - Special cases: result_valid=1 after E0+1.
- DONE: result_valid=1, start_ready=0. result and result_rd_addr are registered and held stable while result_ready=0 (no limit on backpressure).
  - On result_valid&&result_ready -> IDLE; the next accept is possible on the following edge at the earliest (no same-cycle turnaround).
- start_valid while busy is ignored, with no side effects.
- rd_addr=0 computes normally; the register file discards the write.
- Write port: write_enable_3 = result_valid&&result_ready.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> result=0xFFFFFFEB, result_valid exactly 32 cycles after accept; MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2; each at 32-cycle latency, result_rd_addr equals the captured rd_addr.
- Divide by zero: DIV 100/0 -> 0xFFFFFFFF; REM 100/0 -> 100; DIVU 5/0 -> 0xFFFFFFFF; result_valid one cycle after accept.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; one-cycle latency.
- Backpressure: hold result_ready=0 for 5 cycles in DONE -> result, result_rd_addr and result_valid stable; start_ready=0; start_valid pulses ignored. Release -> one handshake, then start_ready=1.
- Async reset: drop rst 10 cycles into a DIV, mid-cycle -> start_ready=1, result_valid=0, busy=0 immediately, without a clock edge. After release, a new MUL 3*4 -> 12.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: a shift-add multiplier and a restoring divider
// share one 2*N_DATA accumulator, with valid/ready handshakes on operand and result sides.
module mul_div_unit #(
   parameter int N_DATA     = 32,
   parameter int N_REG_ADDR = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [2:0]            funct3,
   input  logic [N_DATA-1:0]     operand_a,
   input  logic [N_DATA-1:0]     operand_b,
   input  logic [N_REG_ADDR-1:0] rd_addr,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic [N_DATA-1:0]     result,
   output logic [N_REG_ADDR-1:0] result_rd_addr,
   output logic                  busy,
   output logic                  write_enable_3
);

   localparam int N_CNT = $clog2(N_DATA);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [1:0]              r_op_sel;
   logic [N_REG_ADDR-1:0]   r_rd_addr;
   logic [N_CNT-1:0]        r_count;
   logic                    r_special;
   logic                    r_neg;
   logic                    r_neg_rem;
   logic [N_DATA-1:0]       r_operand;
   logic [2*N_DATA-1:0]     r_acc;
   logic [N_DATA-1:0]       r_result;

   logic                    w_is_div;
   logic                    w_a_signed;
   logic                    w_b_signed;
   logic                    w_a_neg;
   logic                    w_b_neg;
   logic [N_DATA-1:0]       w_a_mag;
   logic [N_DATA-1:0]       w_b_mag;
   logic                    w_div_zero;
   logic                    w_overflow;
   logic                    w_special;
   logic [N_DATA-1:0]       w_special_result;
   logic [N_DATA:0]         w_add;
   logic [2*N_DATA-1:0]     w_mul_acc;
   logic [2*N_DATA-1:0]     w_prod;
   logic [N_DATA-1:0]       w_mul_result;
   logic [N_DATA:0]         w_shift;
   logic [N_DATA:0]         w_trial;
   logic [2*N_DATA-1:0]     w_div_acc;
   logic [N_DATA-1:0]       w_quot;
   logic [N_DATA-1:0]       w_rem;
   logic [N_DATA-1:0]       w_div_result;

   // Operand decode: signedness per op, magnitudes, and the early-exit special cases.
   assign w_is_div   = funct3[2];
   assign w_a_signed = w_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
   assign w_b_signed = w_is_div ? ~funct3[0] : ~funct3[1];
   assign w_a_neg    = w_a_signed & operand_a[N_DATA-1];
   assign w_b_neg    = w_b_signed & operand_b[N_DATA-1];
   assign w_a_mag    = w_a_neg ? -operand_a : operand_a;
   assign w_b_mag    = w_b_neg ? -operand_b : operand_b;
   assign w_div_zero = w_is_div & (operand_b == '0);
   assign w_overflow = w_is_div & ~funct3[0] & (&operand_b)
                       & (operand_a == {1'b1, {(N_DATA-1){1'b0}}});
   assign w_special  = w_div_zero | w_overflow;
   assign w_special_result = w_div_zero ? (funct3[1] ? operand_a : '1)
                                        : (funct3[1] ? '0 : operand_a);

   // Multiply step: conditionally add the multiplicand into the upper half, then shift right.
   assign w_add     = {1'b0, r_acc[2*N_DATA-1:N_DATA]} + {1'b0, r_operand};
   assign w_mul_acc = r_acc[0] ? {w_add, r_acc[N_DATA-1:1]} : {1'b0, r_acc[2*N_DATA-1:1]};
   assign w_prod    = r_neg ? -w_mul_acc : w_mul_acc;
   assign w_mul_result = (r_op_sel == 2'b00) ? w_prod[N_DATA-1:0] : w_prod[2*N_DATA-1:N_DATA];

   // Divide step: upper half holds the partial remainder, lower half shifts dividend out and quotient in.
   assign w_shift   = r_acc[2*N_DATA-1:N_DATA-1];
   assign w_trial   = w_shift - {1'b0, r_operand};
   assign w_div_acc = w_trial[N_DATA] ? {w_shift[N_DATA-1:0], r_acc[N_DATA-2:0], 1'b0}
                                      : {w_trial[N_DATA-1:0], r_acc[N_DATA-2:0], 1'b1};
   assign w_quot    = w_div_acc[N_DATA-1:0];
   assign w_rem     = w_div_acc[2*N_DATA-1:N_DATA];
   assign w_div_result = r_op_sel[1] ? (r_neg_rem ? -w_rem : w_rem)
                                     : (r_neg ? -w_quot : w_quot);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // NOTE: each always_comb assigns its outputs a default first, so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            // Special cases spend one idle-datapath cycle in DIV so they land in DONE one edge after accept.
            if (start_valid) begin
               w_state_next = (w_is_div || w_special) ? DIV : MUL;
            end
         end
         MUL:     if (r_count == '0) w_state_next = DONE;
         DIV:     if (r_count == '0) w_state_next = DONE;
         DONE:    if (result_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      start_ready    = (r_state == IDLE);
      result_valid   = (r_state == DONE);
      busy           = (r_state != IDLE);
      write_enable_3 = result_valid & result_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op_sel  <= '0;
         r_rd_addr <= '0;
         r_count   <= '0;
         r_special <= 1'b0;
         r_neg     <= 1'b0;
         r_neg_rem <= 1'b0;
         r_operand <= '0;
         r_acc     <= '0;
         r_result  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_valid) begin
                  r_op_sel  <= funct3[1:0];
                  r_rd_addr <= rd_addr;
                  r_special <= w_special;
                  r_neg     <= w_a_neg ^ w_b_neg;
                  r_neg_rem <= w_a_neg;
                  r_count   <= w_special ? '0 : N_CNT'(N_DATA - 1);
                  if (w_special) r_result <= w_special_result;
                  if (w_is_div) begin
                     r_operand <= w_b_mag;
                     r_acc     <= {{N_DATA{1'b0}}, w_a_mag};
                  end else begin
                     r_operand <= w_a_mag;
                     r_acc     <= {{N_DATA{1'b0}}, w_b_mag};
                  end
               end
            end
            MUL: begin
               r_acc <= w_mul_acc;
               if (r_count != '0) r_count <= r_count - N_CNT'(1);
               else               r_result <= w_mul_result;
            end
            DIV: begin
               if (!r_special) begin
                  r_acc <= w_div_acc;
                  if (r_count != '0) r_count <= r_count - N_CNT'(1);
                  else               r_result <= w_div_result;
               end
            end
            default: ;
         endcase
      end
   end

   assign result         = r_result;
   assign result_rd_addr = r_rd_addr;

endmodule
